// File: rtl/pcpu_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcpu_run_ctrl_pkg
//  Description : Shared constants for the PCPU run controller: the HALT
//                opcode, host command encodings, FSM state encodings and
//                the FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package pcpu_run_ctrl_pkg;

    // Opcode field [15:11] of the PCPU HALT instruction.
    localparam logic [4:0] HALT_OPC = 5'b00001;

    // Host command encodings.
    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_RUN  = 2'b10;
    localparam logic [1:0] CMD_STEP = 2'b11;

    // FSM state encodings, also visible on the debug state port.
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] RESETC = 3'd2;
    localparam logic [2:0] RUN    = 3'd3;
    localparam logic [2:0] PAUSE  = 3'd4;
    localparam logic [2:0] STEP1  = 3'd5;
    localparam logic [2:0] DRAIN  = 3'd6;
    localparam logic [2:0] HALTED = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = IDLE,
        S_LOAD   = LOAD,
        S_RESETC = RESETC,
        S_RUN    = RUN,
        S_PAUSE  = PAUSE,
        S_STEP1  = STEP1,
        S_DRAIN  = DRAIN,
        S_HALTED = HALTED
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pcpu_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pcpu_run_ctrl_if
//  Description : Host command and program-load bus of the PCPU run
//                controller.
//  Ports       : cmd/cmd_valid/cmd_ready  command handshake
//                ld_we/ld_addr/ld_data    program write port
//                modport master = host side, modport slave = controller side
//  Revision    : 1.0  initial release
// ============================================================================
interface pcpu_run_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [1:0]        cmd;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    modport master (
        output cmd, cmd_valid, ld_we, ld_addr, ld_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd, cmd_valid, ld_we, ld_addr, ld_data,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/pcpu_run_ctrl_cyc_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pcpu_cyc_counter
//  Description : Saturating up-counter with synchronous clear; clear wins
//                over increment.
//  Ports       : clk, rst     clock, synchronous active-high reset
//                i_clr        clear to zero
//                i_inc        count up by one (holds at all-ones)
//                o_count      current count
//  Revision    : 1.0  initial release
// ============================================================================
module pcpu_cyc_counter #(
    parameter int CYC_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output logic [CYC_W-1:0]      o_count
);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            o_count <= '0;
        end else if (i_inc && (o_count != {CYC_W{1'b1}})) begin
            o_count <= o_count + CYC_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pcpu_run_ctrl
//  Description : Run controller for the PCPU pipelined core. Loads the
//                instruction RAM from the host, resets/starts the core,
//                supports free-run and single-step, and on HALT drains the
//                pipeline before freezing the core.
//  Ports       : clock, reset          clock, synchronous active-high reset
//                host (slave)          command handshake + program write bus
//                imem_we/waddr/wdata   instruction RAM write port
//                cpu_i_datain          instruction word seen by the core
//                cpu_reset/start/enable core controls
//                cycle_count, halted   run status
//                state                 FSM state (debug)
//  Options     : PCPU_BREAKPOINT_EN adds bp_valid, bp_addr, cpu_i_addr and
//                pauses RUN on an instruction-address match.
//  Revision    : 1.0  initial release
// ============================================================================
module pcpu_run_ctrl
    import pcpu_run_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int CYC_W     = 16,
    parameter int DRAIN_CYC = 4
) (
    input  wire logic              clock,
    input  wire logic              reset,
    pcpu_run_ctrl_if.slave         host,
    output logic                   imem_we,
    output logic [ADDR_W-1:0]      imem_waddr,
    output logic [DATA_W-1:0]      imem_wdata,
    input  wire logic [DATA_W-1:0] cpu_i_datain,
    output logic                   cpu_reset,
    output logic                   cpu_start,
    output logic                   cpu_enable,
    output logic [CYC_W-1:0]       cycle_count,
    output logic                   halted,
    output logic [2:0]             state
`ifdef PCPU_BREAKPOINT_EN
    ,
    input  wire logic              bp_valid,
    input  wire logic [ADDR_W-1:0] bp_addr,
    input  wire logic [ADDR_W-1:0] cpu_i_addr
`endif
);

    // Drain counter holds the enabled cycles still owed after the HALT fetch.
    localparam int                   c_DRAIN_W    = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(DRAIN_CYC - 1);
    // With a one-cycle drain the HALT-fetch cycle is the whole drain.
    localparam state_t               c_HALT_NEXT  = (DRAIN_CYC > 1) ? S_DRAIN : S_HALTED;

    state_t               r_state;
    state_t               w_next;
    logic                 r_go_run;
    logic                 w_go_run;
    logic [c_DRAIN_W-1:0] r_drain;
    logic                 r_halted;
    logic                 w_accept;
    logic                 w_halt_fetch;
    logic                 w_bp_hit;
    logic                 w_cnt_clr;
    logic                 w_unused_opnd;

    assign w_accept      = host.cmd_valid && host.cmd_ready;
    assign w_halt_fetch  = (cpu_i_datain[15:11] == HALT_OPC);
    assign w_unused_opnd = ^cpu_i_datain[10:0];

`ifdef PCPU_BREAKPOINT_EN
    // After a breakpoint pause, the resuming RUN cycle ignores the match so
    // the core can move past the breakpointed instruction.
    logic r_bp_skip;

    assign w_bp_hit = bp_valid && (cpu_i_addr == bp_addr) && !r_bp_skip;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bp_skip <= 1'b0;
        end else if ((r_state == S_RUN) && (w_next == S_PAUSE)) begin
            r_bp_skip <= 1'b1;
        end else if ((r_state == S_RUN) || (r_state == S_RESETC)) begin
            r_bp_skip <= 1'b0;
        end
    end
`else
    assign w_bp_hit = 1'b0;
`endif

    always_comb begin
        w_next   = r_state;
        w_go_run = r_go_run;
        case (r_state)
            // IDLE, LOAD and HALTED share one command map.
            S_IDLE, S_LOAD, S_HALTED: begin
                if (w_accept) begin
                    case (host.cmd)
                        CMD_STOP: w_next = S_IDLE;
                        CMD_LOAD: w_next = S_LOAD;
                        CMD_RUN: begin
                            w_next   = S_RESETC;
                            w_go_run = 1'b1;
                        end
                        default: begin
                            w_next   = S_RESETC;
                            w_go_run = 1'b0;
                        end
                    endcase
                end
            end
            S_RESETC: w_next = r_go_run ? S_RUN : S_PAUSE;
            S_RUN: begin
                if (w_accept && (host.cmd == CMD_STOP)) begin
                    w_next = S_IDLE;
                end else if (w_halt_fetch) begin
                    w_next = c_HALT_NEXT;
                end else if (w_bp_hit) begin
                    w_next = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (w_accept) begin
                    case (host.cmd)
                        CMD_STOP: w_next = S_IDLE;
                        CMD_RUN:  w_next = S_RUN;
                        CMD_STEP: w_next = S_STEP1;
                        default:  w_next = S_PAUSE;
                    endcase
                end
            end
            S_STEP1: w_next = w_halt_fetch ? c_HALT_NEXT : S_PAUSE;
            S_DRAIN: begin
                if (r_drain <= c_DRAIN_W'(1)) begin
                    w_next = S_HALTED;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_go_run <= 1'b0;
            r_drain  <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_go_run <= w_go_run;
            if ((w_next == S_DRAIN) && (r_state != S_DRAIN)) begin
                r_drain <= c_DRAIN_LOAD;
            end else if (r_state == S_DRAIN) begin
                r_drain <= r_drain - c_DRAIN_W'(1);
            end
            // Cleared on entry to RESETC so the reset cycle already shows 0.
            if (w_next == S_RESETC) begin
                r_halted <= 1'b0;
            end else if (w_next == S_HALTED) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign w_cnt_clr = (w_next == S_RESETC);

    pcpu_cyc_counter #(
        .CYC_W (CYC_W)
    ) u_cyc_counter (
        .clk     (clock),
        .rst     (reset),
        .i_clr   (w_cnt_clr),
        .i_inc   (cpu_enable),
        .o_count (cycle_count)
    );

    assign host.cmd_ready = !((r_state == S_RESETC) || (r_state == S_DRAIN));
    assign imem_we        = (r_state == S_LOAD) && host.ld_we;
    assign imem_waddr     = host.ld_addr;
    assign imem_wdata     = host.ld_data;
    assign cpu_reset      = (r_state == S_RESETC);
    assign cpu_enable     = (r_state == S_RUN) || (r_state == S_STEP1) || (r_state == S_DRAIN);
    assign cpu_start      = cpu_enable || (r_state == S_PAUSE);
    assign halted         = r_halted;
    assign state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pcpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcpu_run_ctrl
//  Description : Self-checking bench for pcpu_run_ctrl: program-load table,
//                hand-written run/step/stop/reset sequences, then random
//                commands against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pcpu_run_ctrl;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int CYC_W     = 16;
    localparam int DRAIN_CYC = 4;

    localparam logic [4:0] OPC_HALT = 5'b00001;
    localparam logic [1:0] C_STOP = 2'd0, C_LOAD = 2'd1, C_RUN = 2'd2, C_STEP = 2'd3;
    localparam int ST_IDLE = 0, ST_LOAD = 1, ST_RESETC = 2, ST_RUN = 3;
    localparam int ST_PAUSE = 4, ST_STEP1 = 5, ST_DRAIN = 6, ST_HALTED = 7;

    logic              clock = 1'b0;
    logic              reset;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;
    logic [DATA_W-1:0] cpu_i_datain;
    logic              cpu_reset, cpu_start, cpu_enable, halted;
    logic [CYC_W-1:0]  cycle_count;
    logic [2:0]        state;
`ifdef PCPU_BREAKPOINT_EN
    logic              bp_valid;
    logic [ADDR_W-1:0] bp_addr;
    logic [ADDR_W-1:0] cpu_i_addr;
`endif

    always #5 clock = ~clock;

    pcpu_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host ();

    pcpu_run_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .host         (host),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .cpu_i_datain (cpu_i_datain),
        .cpu_reset    (cpu_reset),
        .cpu_start    (cpu_start),
        .cpu_enable   (cpu_enable),
        .cycle_count  (cycle_count),
        .halted       (halted),
        .state        (state)
`ifdef PCPU_BREAKPOINT_EN
        ,
        .bp_valid     (bp_valid),
        .bp_addr      (bp_addr),
        .cpu_i_addr   (cpu_i_addr)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        logic        we;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [15:0] exp_data;
        logic        exp_en;
    } ld_vec_t;

    ld_vec_t     ld_tab [12];
    logic [15:0] prog   [16];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // {state, cmd_ready, cpu_reset, cpu_start, cpu_enable, halted, imem_we, cycle_count}
    function automatic logic [24:0] got_vec();
        return {state, host.cmd_ready, cpu_reset, cpu_start, cpu_enable, halted, imem_we, cycle_count};
    endfunction

    function automatic logic [24:0] exp_vec(input int st, input bit rdy, input bit rs, input bit sta,
                                            input bit en, input bit hl, input bit we, input int cnt);
        return {3'(st), rdy, rs, sta, en, hl, we, 16'(cnt)};
    endfunction

    task automatic clk_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        host.cmd       = C_STOP;
        host.cmd_valid = 1'b0;
        host.ld_we     = 1'b0;
        host.ld_addr   = '0;
        host.ld_data   = '0;
    endtask

    task automatic send(input logic [1:0] c);
        host.cmd       = c;
        host.cmd_valid = 1'b1;
        clk_step();
        host.cmd_valid = 1'b0;
    endtask

    // ---------------- reference model state ----------------
    int m_mode, m_count, m_left;
    bit m_halted, m_after_run;

    function automatic bit m_enable();
        return (m_mode == ST_RUN) || (m_mode == ST_STEP1) || (m_mode == ST_DRAIN);
    endfunction

    function automatic bit m_ready();
        return !((m_mode == ST_RESETC) || (m_mode == ST_DRAIN));
    endfunction

    task automatic m_advance(input bit rst, input bit v, input logic [1:0] c, input logic [15:0] w);
        bit acc, hlt;
        if (rst) begin
            m_mode = ST_IDLE; m_count = 0; m_halted = 0;
            return;
        end
        acc = v && m_ready();
        hlt = (w[15:11] == OPC_HALT);
        if (m_enable() && m_count < (1 << CYC_W) - 1) m_count++;
        case (m_mode)
            ST_IDLE, ST_LOAD, ST_HALTED:
                if (acc) begin
                    if (c == C_STOP) m_mode = ST_IDLE;
                    else if (c == C_LOAD) m_mode = ST_LOAD;
                    else begin
                        m_mode = ST_RESETC; m_after_run = (c == C_RUN);
                        m_count = 0; m_halted = 0;
                    end
                end
            ST_RESETC: m_mode = m_after_run ? ST_RUN : ST_PAUSE;
            ST_RUN:
                if (acc && c == C_STOP) m_mode = ST_IDLE;
                else if (hlt) begin m_mode = ST_DRAIN; m_left = DRAIN_CYC - 1; end
            ST_PAUSE:
                if (acc) begin
                    if (c == C_STOP) m_mode = ST_IDLE;
                    else if (c == C_RUN) m_mode = ST_RUN;
                    else if (c == C_STEP) m_mode = ST_STEP1;
                end
            ST_STEP1:
                if (hlt) begin m_mode = ST_DRAIN; m_left = DRAIN_CYC - 1; end
                else m_mode = ST_PAUSE;
            default: begin
                m_left--;
                if (m_left == 0) begin m_mode = ST_HALTED; m_halted = 1; end
            end
        endcase
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc, k, rc, en, hidx, pulses;
        bit r, v;
        logic [1:0]  c;
        logic [15:0] w;

        // program: LOAD gr1, LOAD gr2, NOPx3, ADD gr3, NOPx3, STORE, HALT
        prog = '{16'h1100, 16'h1201, 16'h0000, 16'h0000, 16'h0000, 16'h4312,
                 16'h0000, 16'h0000, 16'h0000, 16'h1B02, 16'h0800, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < 11; i++)
            ld_tab[i] = '{8'(i), prog[i], 1'b1, 1'b1, 8'(i), prog[i], 1'b0};
        ld_tab[11] = '{8'h3C, 16'hBEEF, 1'b0, 1'b0, 8'h3C, 16'hBEEF, 1'b0};

        idle_inputs();
        cpu_i_datain = '0;
`ifdef PCPU_BREAKPOINT_EN
        bp_valid = 1'b0; bp_addr = '0; cpu_i_addr = '0;
`endif
        reset = 1'b1;
        clk_step();
        clk_step();
        check("reset_state", 64'(got_vec()), 64'(exp_vec(ST_IDLE, 1, 0, 0, 0, 0, 0, 0)));
        reset = 1'b0;

        // ---- program load from the table ----
        send(C_LOAD);
        check("load_state", 64'(state), 64'(ST_LOAD));
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            host.ld_we = ld_tab[i].we; host.ld_addr = ld_tab[i].addr; host.ld_data = ld_tab[i].data;
            #1;
            check("load_we", 64'(imem_we), 64'(ld_tab[i].exp_we));
            if (ld_tab[i].exp_we) check("load_addr_data", 64'({imem_waddr, imem_wdata}),
                                        64'({ld_tab[i].exp_addr, ld_tab[i].exp_data}));
            check("load_enable", 64'(cpu_enable), 64'(ld_tab[i].exp_en));
            if (imem_we) pulses++;
            clk_step();
        end
        host.ld_we = 1'b0;
        check("load_pulses", 64'(pulses), 64'd11);

        // ---- RUN to HALT with a simple fetch model ----
        send(C_RUN);
        pc = 0; k = 0; rc = 0; en = 0; hidx = -1;
        while (!halted && k < 100) begin
            cpu_i_datain = prog[pc];
            #1;
            if (cpu_reset) rc++;
            if (cpu_enable) begin
                if (prog[pc][15:11] == OPC_HALT && hidx < 0) hidx = en;
                en++; pc++;
            end
            clk_step(); k++;
        end
        check("run_timeout", 64'(k < 100), 64'd1);
        check("run_reset_cycles", 64'(rc), 64'd1);
        check("run_halt_index", 64'(hidx), 64'd10);
        check("run_enable_cycles", 64'(en), 64'd14);
        check("run_final", 64'(got_vec()), 64'(exp_vec(ST_HALTED, 1, 0, 0, 0, 1, 0, 14)));

        // ---- STOP from HALTED keeps halted, then STEP x3 ----
        cpu_i_datain = 16'h0000;
        send(C_STOP);
        check("stop_keeps_halted", 64'({state, halted}), 64'({3'(ST_IDLE), 1'b1}));
        send(C_STEP);
        check("step_resetc", 64'(got_vec()), 64'(exp_vec(ST_RESETC, 0, 1, 0, 0, 0, 0, 0)));
        clk_step();
        check("step_pause", 64'(got_vec()), 64'(exp_vec(ST_PAUSE, 1, 0, 1, 0, 0, 0, 0)));
        for (int i = 0; i < 3; i++) begin
            send(C_STEP);
            check("step1_enable", 64'({state, cpu_enable}), 64'({3'(ST_STEP1), 1'b1}));
            clk_step();
            check("step_back_pause", 64'({state, cpu_enable}), 64'({3'(ST_PAUSE), 1'b0}));
        end
        check("step_count", 64'(cycle_count), 64'd3);

        // ---- STOP during RUN at cycle_count 5 ----
        send(C_STOP);
        send(C_RUN);
        k = 0;
        while (!(state == 3'(ST_RUN) && cycle_count == 16'd5) && k < 50) begin
            clk_step(); k++;
        end
        check("stop_wait", 64'(k < 50), 64'd1);
        send(C_STOP);
        check("stop_in_run", 64'(got_vec()), 64'(exp_vec(ST_IDLE, 1, 0, 0, 0, 0, 0, 6)));

        // ---- reset while draining ----
        cpu_i_datain = 16'h0800;
        send(C_RUN);
        k = 0;
        while (state != 3'(ST_DRAIN) && k < 20) begin
            clk_step(); k++;
        end
        check("drain_wait", 64'(k < 20), 64'd1);
        check("drain_not_ready", 64'(host.cmd_ready), 64'd0);
        reset = 1'b1;
        clk_step();
        check("reset_in_drain", 64'(got_vec()), 64'(exp_vec(ST_IDLE, 1, 0, 0, 0, 0, 0, 0)));
        reset = 1'b0;
        cpu_i_datain = 16'h0000;

`ifdef PCPU_BREAKPOINT_EN
        // ---- breakpoint at address 5, then resume to HALT ----
        bp_addr = 8'h05; bp_valid = 1'b1;
        send(C_RUN);
        pc = 0; k = 0;
        while (state != 3'(ST_PAUSE) && k < 50) begin
            cpu_i_addr = 8'(pc); cpu_i_datain = prog[pc];
            #1;
            if (cpu_enable && pc != 5) pc++;
            clk_step(); k++;
        end
        check("bp_pause", 64'({state, cpu_enable, 8'(pc)}), 64'({3'(ST_PAUSE), 1'b0, 8'h05}));
        send(C_RUN);
        k = 0;
        while (!halted && k < 50) begin
            cpu_i_addr = 8'(pc); cpu_i_datain = prog[pc];
            #1;
            if (cpu_enable) pc++;
            clk_step(); k++;
        end
        check("bp_resume_halt", 64'({halted, 1'(k < 50)}), 64'({1'b1, 1'b1}));
        bp_valid = 1'b0;
        send(C_STOP);
`endif

        // ---- randomized commands against the reference model ----
        reset = 1'b1;
        clk_step();
        m_advance(1'b1, 1'b0, C_STOP, 16'h0000);
        reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(99) == 0);
            v = 1'($urandom_range(1));
            c = 2'($urandom_range(3));
            w = 16'($urandom);
            if ($urandom_range(5) == 0) w[15:11] = OPC_HALT;
            reset = r; host.cmd = c; host.cmd_valid = v; cpu_i_datain = w;
            host.ld_we = 1'($urandom_range(1));
            host.ld_addr = 8'($urandom); host.ld_data = 16'($urandom);
`ifdef PCPU_BREAKPOINT_EN
            cpu_i_addr = 8'($urandom);
`endif
            #1;
            check("random_outputs", 64'(got_vec()),
                  64'(exp_vec(m_mode, m_ready(), m_mode == ST_RESETC, m_enable() || m_mode == ST_PAUSE,
                              m_enable(), m_halted, m_mode == ST_LOAD && host.ld_we, m_count)));
            if (m_mode == ST_LOAD && host.ld_we)
                check("random_load_bus", 64'({imem_waddr, imem_wdata}), 64'({host.ld_addr, host.ld_data}));
            @(posedge clock);
            m_advance(r, v, c, w);
            #1;
        end
        reset = 1'b0;
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcpu_run_ctrl.md
Name: pcpu_run_ctrl

Overview:
Run controller that sequences the PCPU pipelined core from a host command interface.
- Loads a program into the instruction RAM over a host write port.
- Resets and starts the core, and supports free-run and single-step.
- Detects HALT, drains the pipeline, then freezes the core and reports the cycle count.
- Sits between the host/loader, the instruction RAM write port and the PCPU clock/enable controls.

Parameters:
ADDR_W, 8, instruction address width (matches PCPU i_addr)
DATA_W, 16, instruction word width
CYC_W, 16, cycle counter width
DRAIN_CYC, 4, cycles enable stays high after HALT is fetched so in-flight instructions retire

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
cmd  in  2  host command: 00 STOP, 01 LOAD, 10 RUN, 11 STEP
cmd_valid  in  1  command strobe
cmd_ready  out  1  controller can accept cmd this cycle
ld_we  in  1  host program write strobe (honoured only in LOAD)
ld_addr  in  ADDR_W  host program write address
ld_data  in  DATA_W  host program write word
imem_we  out  1  instruction RAM write enable
imem_waddr  out  ADDR_W  instruction RAM write address
imem_wdata  out  DATA_W  instruction RAM write data
cpu_i_datain  in  DATA_W  instruction word currently presented to PCPU i_datain
cpu_reset  out  1  reset to PCPU
cpu_start  out  1  PCPU start
cpu_enable  out  1  PCPU enable
cycle_count  out  CYC_W  enabled cycles since last RUN/STEP-from-idle
halted  out  1  HALT retired, core frozen
state  out  3  FSM state encoding (debug)

Behaviour:
- Reset values: state=IDLE, all outputs 0 except cmd_ready=1.
- A command is accepted when cmd_valid && cmd_ready. cmd_ready=0 only in RESETC and DRAIN.
- IDLE:
  - LOAD -> LOAD.
  - RUN -> RESETC(next=RUN).
  - STEP -> RESETC(next=PAUSE), then first step.
  - STOP: no-op.
- LOAD:
  - imem_we=ld_we, imem_waddr=ld_addr, imem_wdata=ld_data, combinational pass-through.
  - imem_we=0 in every other state.
  - RUN and STEP behave as in IDLE. STOP -> IDLE.
- RESETC: one cycle.
  - cpu_reset=1, cycle_count cleared, halted cleared.
  - Next cycle: RUN or PAUSE.
- RUN: cpu_start=1, cpu_enable=1.
  - cycle_count +1 per cycle, saturating at all-ones.
  - opcode cpu_i_datain[15:11]==HALT_OPC -> DRAIN; the drain counter loads DRAIN_CYC-1.
  - STOP -> IDLE: start/enable drop on the next cycle; halted stays 0.
- PAUSE: cpu_start=1, cpu_enable=0.
  - STEP -> STEP1.
  - RUN -> RUN, without reset.
  - STOP -> IDLE.
- STEP1: one cycle, cpu_enable=1, cycle_count +1.
  - HALT fetched this cycle -> DRAIN.
  - Otherwise -> PAUSE.
- DRAIN: enable=1 for exactly DRAIN_CYC cycles in total, counting the HALT-fetch cycle; counted in cycle_count.
  - Then -> HALTED.
  - Commands are not accepted.
- HALTED: start=0, enable=0, halted=1; cycle_count held.
  - RUN or STEP -> RESETC; halted clears there.
  - LOAD -> LOAD; halted stays 1 until the next RESETC.
  - STOP -> IDLE.
- Reset mid-operation overrides everything, landing in IDLE next cycle.
- LOAD-while-running is impossible: LOAD is accepted only in IDLE/HALTED.

Optional Feature:
PCPU_BREAKPOINT_EN
- Adds ports bp_valid (in, 1), bp_addr (in, ADDR_W) and cpu_i_addr (in, ADDR_W).
- In RUN, cpu_i_addr==bp_addr with bp_valid=1 -> PAUSE, with enable=0 from the next cycle. The breakpointed instruction has been fetched but not advanced.
- A following RUN ignores a match at the same address for one cycle.
- Without the macro: no ports, no breakpoint logic.

Decomposition:
- Shared package/header holds:
  - HALT_OPC, equal to the existing HALT opcode from the common header;
  - cmd encodings CMD_STOP/LOAD/RUN/STEP;
  - FSM state localparams IDLE=0, LOAD=1, RESETC=2, RUN=3, PAUSE=4, STEP1=5, DRAIN=6, HALTED=7.
- One natural sub-module: pcpu_cyc_counter, a saturating CYC_W counter with clear and inc.

Test Plan:
- LOAD, write {LOAD gr1}, {LOAD gr2}, NOP×3, {ADD gr3}, NOP×3, {STORE}, {HALT} at addr 0..10 -> imem_we pulses 11 times with matching addr/data; cpu_enable stays 0.
- RUN after load -> cpu_reset high exactly 1 cycle, then start=enable=1; HALT fetch then enable high 4 cycles total; halted=1; cycle_count = HALT-fetch cycle index + 4.
- STEP from IDLE, then 3 STEP cmds -> one cycle reset, then enable high exactly 1 cycle per STEP; cycle_count=3; state returns to PAUSE(4).
- STOP during RUN at cycle_count=5 -> enable=0 next cycle; state=IDLE; halted=0; count held at 6.
- Assert reset during DRAIN -> next cycle all outputs 0, cmd_ready=1, state=0.
- (PCPU_BREAKPOINT_EN) bp_addr=8'h05, RUN -> PAUSE when cpu_i_addr==05; subsequent RUN proceeds past 05 to HALT.
